// File: rtl/text_console_writer_if.sv
// text_console_writer_if: character input handshake, text memory port B and cursor/status signals.
interface text_console_writer_if #(
    parameter int ADDR_W = 15,
    parameter int COL_W  = 8,
    parameter int ROW_W  = 7
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_char;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic [7:0]        mem_rdata;
    logic [ROW_W-1:0]  cursor_row;
    logic [COL_W-1:0]  cursor_col;
    logic              busy;
    modport master (
        input  in_valid, in_char, mem_rdata,
        output in_ready, mem_addr, mem_wdata, mem_we, cursor_row, cursor_col, busy
    );
    modport slave (
        output in_valid, in_char, mem_rdata,
        input  in_ready, mem_addr, mem_wdata, mem_we, cursor_row, cursor_col, busy
    );
endinterface

// File: rtl/text_console_writer.sv
// text_console_writer: turns a character stream into text memory writes, with cursor, control codes, scroll and clear.
module text_console_writer #(
    parameter int COLS   = 160,
    parameter int ROWS   = 128,
    parameter int ADDR_W = 15,
    parameter int COL_W  = 8,
    parameter int ROW_W  = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    text_console_writer_if.master bus
);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [ADDR_W-1:0] COPY_END  = ADDR_W'((ROWS - 1) * COLS - 1);
    localparam logic [ADDR_W-1:0] A_END     = ADDR_W'(ROWS * COLS - 1);
    localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(ROWS - 1);

    typedef enum logic [2:0] {S_IDLE, S_SCR_RD, S_SCR_WAIT, S_SCR_WR, S_SCR_CLR, S_CLEAR} state_t;

    state_t            r_state, w_state;
    logic [ADDR_W-1:0] r_cnt, w_cnt;
    logic [ROW_W-1:0]  r_row, w_row;
    logic [COL_W-1:0]  r_col, w_col;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
    logic [7:0]        r_mem_wdata, w_mem_wdata;
    logic              r_mem_we, w_mem_we;
    logic              w_accept, w_last_col, w_last_row;
    logic [ADDR_W-1:0] w_line;

    assign w_accept   = bus.in_valid && (r_state == S_IDLE);
    assign w_last_col = (r_col == COL_MAX);
    assign w_last_row = (r_row == ROW_MAX);
    assign w_line     = r_addr - ADDR_W'(r_col);

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_row       = r_row;
        w_col       = r_col;
        w_addr      = r_addr;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_mem_we    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (bus.in_char >= 8'h20 && bus.in_char <= 8'h7E) begin
                        w_mem_addr  = r_addr;
                        w_mem_wdata = bus.in_char;
                        w_mem_we    = 1'b1;
                        w_col       = w_last_col ? '0 : r_col + 1'b1;
                        w_row       = (w_last_col && !w_last_row) ? r_row + 1'b1 : r_row;
                        w_addr      = (w_last_col && w_last_row) ? LAST_BASE : r_addr + 1'b1;
                        w_state     = (w_last_col && w_last_row) ? S_SCR_RD : S_IDLE;
                        w_cnt       = '0;
                    end else if (bus.in_char == 8'h0A) begin
                        w_col   = '0;
                        w_row   = w_last_row ? r_row : r_row + 1'b1;
                        w_addr  = w_last_row ? w_line : w_line + COLS_A;
                        w_state = w_last_row ? S_SCR_RD : S_IDLE;
                        w_cnt   = '0;
                    end else if (bus.in_char == 8'h0D) begin
                        w_col  = '0;
                        w_addr = w_line;
                    end else if (bus.in_char == 8'h08 && r_col != '0) begin
                        w_col       = r_col - 1'b1;
                        w_addr      = r_addr - 1'b1;
                        w_mem_addr  = r_addr - 1'b1;
                        w_mem_wdata = 8'h20;
                        w_mem_we    = 1'b1;
                    end else if (bus.in_char == 8'h0C) begin
                        w_state = S_CLEAR;
                        w_cnt   = '0;
                    end
                end
            end
            S_SCR_RD: begin
                w_mem_addr = r_cnt + COLS_A;
                w_state    = S_SCR_WAIT;
            end
            S_SCR_WAIT: w_state = S_SCR_WR;
            S_SCR_WR: begin
                // rdata is valid now, one cycle after the read address left the output register
                w_mem_addr  = r_cnt;
                w_mem_wdata = bus.mem_rdata;
                w_mem_we    = 1'b1;
                w_cnt       = r_cnt + 1'b1;
                w_state     = (r_cnt == COPY_END) ? S_SCR_CLR : S_SCR_RD;
            end
            S_SCR_CLR, S_CLEAR: begin
                w_mem_addr  = r_cnt;
                w_mem_wdata = 8'h20;
                w_mem_we    = 1'b1;
                w_cnt       = r_cnt + 1'b1;
                w_state     = (r_cnt == A_END) ? S_IDLE : r_state;
                if (r_state == S_CLEAR && r_cnt == A_END) begin
                    w_row  = '0;
                    w_col  = '0;
                    w_addr = '0;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_addr      <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_row       <= w_row;
            r_col       <= w_col;
            r_addr      <= w_addr;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_mem_we    <= w_mem_we;
        end
    end

    assign bus.in_ready   = (r_state == S_IDLE);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_we     = r_mem_we;
    assign bus.cursor_row = r_row;
    assign bus.cursor_col = r_col;
endmodule

// File: tb/tb_text_console_writer.sv
// tb_text_console_writer: directed stimulus on a 4x3 screen, screen/cursor model checked every cycle plus literal expectations.
module tb_text_console_writer;
    localparam int COLS = 4;
    localparam int ROWS = 3;
    localparam int N    = COLS * ROWS;
    localparam int SCROLL_CYC = 3 * (ROWS - 1) * COLS + COLS;

    logic clk;
    logic reset;
    logic load_req;
    bit   chk_en;
    int   checks;
    int   errors;

    text_console_writer_if #(.ADDR_W(4), .COL_W(2), .ROW_W(2)) bus ();

    text_console_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(4), .COL_W(2), .ROW_W(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'(8'h30 + i);
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    // Screen model: cursor in row/col terms, contents as a flat array, busy as a cycle countdown
    logic [7:0] m_scr [16];
    int         m_row, m_col, m_busy_left;
    bit         m_scrolling, m_exp_check, m_exp_we;
    int         m_exp_addr;
    logic [7:0] m_exp_data;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 16; i++) m_scr[i] <= 8'(8'h30 + i);
        end
        if (reset) begin
            m_row <= 0;
            m_col <= 0;
            m_busy_left <= 0;
            m_exp_check <= 1'b1;
            m_exp_we <= 1'b0;
        end else if (m_busy_left > 0) begin
            m_busy_left <= m_busy_left - 1;
            m_exp_check <= 1'b0;
            m_exp_we <= 1'b0;
            if (m_busy_left == 1) begin
                m_col <= 0;
                m_row <= m_scrolling ? ROWS - 1 : 0;
                if (m_scrolling) begin
                    for (int i = 0; i < N - COLS; i++) m_scr[i] <= m_scr[i + COLS];
                    for (int i = N - COLS; i < N; i++) m_scr[i] <= 8'h20;
                end else begin
                    for (int i = 0; i < N; i++) m_scr[i] <= 8'h20;
                end
            end
        end else begin
            m_exp_check <= 1'b1;
            m_exp_we <= 1'b0;
            if (bus.in_valid) begin
                if (bus.in_char >= 8'h20 && bus.in_char <= 8'h7E) begin
                    m_exp_we <= 1'b1;
                    m_exp_addr <= m_row * COLS + m_col;
                    m_exp_data <= bus.in_char;
                    m_scr[m_row * COLS + m_col] <= bus.in_char;
                    if (m_col == COLS - 1) begin
                        m_col <= 0;
                        if (m_row == ROWS - 1) begin
                            m_busy_left <= SCROLL_CYC;
                            m_scrolling <= 1'b1;
                        end else m_row <= m_row + 1;
                    end else m_col <= m_col + 1;
                end else if (bus.in_char == 8'h0A) begin
                    m_col <= 0;
                    if (m_row == ROWS - 1) begin
                        m_busy_left <= SCROLL_CYC;
                        m_scrolling <= 1'b1;
                    end else m_row <= m_row + 1;
                end else if (bus.in_char == 8'h0D) begin
                    m_col <= 0;
                end else if (bus.in_char == 8'h08) begin
                    if (m_col > 0) begin
                        m_col <= m_col - 1;
                        m_exp_we <= 1'b1;
                        m_exp_addr <= m_row * COLS + m_col - 1;
                        m_exp_data <= 8'h20;
                        m_scr[m_row * COLS + m_col - 1] <= 8'h20;
                    end
                end else if (bus.in_char == 8'h0C) begin
                    m_busy_left <= N;
                    m_scrolling <= 1'b0;
                    m_exp_check <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] c);
        bus.in_valid = 1'b1;
        bus.in_char = c;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic check_screen(input string name);
        for (int i = 0; i < N; i++) chk(name, 32'(mem[i]), 32'(m_scr[i]));
    endtask

    task automatic check_cursor(input int row, input int col);
        chk("cursor_row", 32'(bus.cursor_row), 32'(row));
        chk("cursor_col", 32'(bus.cursor_col), 32'(col));
    endtask

    logic [7:0] scroll_lit [12] = '{8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h3A, 8'h5A,
                                   8'h20, 8'h20, 8'h20, 8'h20};

    initial begin
        int busy_cnt;
        int n;
        reset = 1'b1;
        load_req = 1'b0;
        chk_en = 1'b0;
        checks = 0;
        errors = 0;
        bus.in_valid = 1'b0;
        bus.in_char = 8'h00;
        fork
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    chk("model_in_ready", 32'(bus.in_ready), 32'(m_busy_left == 0));
                    chk("model_busy", 32'(bus.busy), 32'(m_busy_left != 0));
                    if (m_busy_left == 0) begin
                        chk("model_row", 32'(bus.cursor_row), 32'(m_row));
                        chk("model_col", 32'(bus.cursor_col), 32'(m_col));
                    end
                    if (m_exp_check) begin
                        chk("model_we", 32'(bus.mem_we), 32'(m_exp_we));
                        if (m_exp_we) begin
                            chk("model_addr", 32'(bus.mem_addr), 32'(m_exp_addr));
                            chk("model_wdata", 32'(bus.mem_wdata), 32'(m_exp_data));
                        end
                    end
                end
            end
        join_none
        repeat (2) @(negedge clk);
        load();
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_we", 32'(bus.mem_we), 0);
        chk("rst_addr", 32'(bus.mem_addr), 0);
        chk("rst_wdata", 32'(bus.mem_wdata), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ready", 32'(bus.in_ready), 1);
        check_cursor(0, 0);

        send(8'h41);
        chk("a_we", 32'(bus.mem_we), 1);
        chk("a_addr", 32'(bus.mem_addr), 0);
        chk("a_wdata", 32'(bus.mem_wdata), 32'h41);
        chk("a_ready", 32'(bus.in_ready), 1);
        check_cursor(0, 1);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(8'(8'h41 + i));
            chk("abcd_addr", 32'(bus.mem_addr), 32'(i));
            chk("abcd_we", 32'(bus.mem_we), 1);
        end
        check_cursor(1, 0);
        send("a");
        send("b");
        send(8'h0A);
        chk("lf_we", 32'(bus.mem_we), 0);
        check_cursor(2, 0);
        send(8'h0D);
        check_cursor(2, 0);
        send(8'h08);
        chk("bs0_we", 32'(bus.mem_we), 0);
        check_cursor(2, 0);

        send("a");
        send("b");
        send("c");
        load();
        send("Z");
        chk("z_we", 32'(bus.mem_we), 1);
        chk("z_addr", 32'(bus.mem_addr), 11);
        chk("z_wdata", 32'(bus.mem_wdata), 32'h5A);
        bus.in_valid = 1'b1;
        bus.in_char = "Q";
        busy_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (!bus.busy) break;
            busy_cnt++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("scroll_busy_cycles", 32'(busy_cnt), 32'(SCROLL_CYC));
        repeat (2) @(negedge clk);
        check_cursor(2, 0);
        for (int i = 0; i < N; i++) chk("scroll_mem", 32'(mem[i]), 32'(scroll_lit[i]));
        check_screen("scroll_model");

        do_reset();
        send(8'h0A);
        send("a");
        send("b");
        send(8'h08);
        chk("bs_we", 32'(bus.mem_we), 1);
        chk("bs_addr", 32'(bus.mem_addr), 5);
        chk("bs_wdata", 32'(bus.mem_wdata), 32'h20);
        check_cursor(1, 1);

        send(8'h0C);
        n = 0;
        repeat (20) begin
            if (bus.mem_we) begin
                chk("clr_addr", 32'(bus.mem_addr), 32'(n));
                chk("clr_wdata", 32'(bus.mem_wdata), 32'h20);
                n++;
            end
            @(negedge clk);
        end
        chk("clr_writes", 32'(n), 32'(N));
        check_cursor(0, 0);
        check_screen("clear_model");

        load();
        send("k");
        send(8'h0C);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_we", 32'(bus.mem_we), 0);
        chk("abort_ready", 32'(bus.in_ready), 1);
        check_cursor(0, 0);
        for (int i = 5; i < N; i++) chk("abort_untouched", 32'(mem[i]), 32'(8'h30 + i));
        @(negedge clk);
        chk("abort_we2", 32'(bus.mem_we), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Upstream producer for the VGA text-mode display. Converts a byte stream of characters into writes on port B of the dual-port text memory.
- The display controller reads port A of the same memory.
- Keeps a cursor and handles control characters (newline, carriage return, backspace, form feed).
- When the cursor passes the last row, the whole screen scrolls up by one row using a read/copy/clear sequence.

Parameters:
COLS, 160, characters per row (1280 px / 8)
ROWS, 128, rows on screen (1024 px / 8)
ADDR_W, 15, text memory address width; must satisfy COLS*ROWS <= 2^ADDR_W
COL_W, 8, cursor column width
ROW_W, 7, cursor row width

Ports:
clk  in  1  pixel clock, same clock as the text memory
reset  in  1  synchronous, active-high
in_valid  in  1  in_char is valid
in_ready  out  1  block can accept a character this cycle
in_char  in  8  ASCII character or control code
mem_addr  out  ADDR_W  text memory port B address, linear row*COLS+col
mem_wdata  out  8  write data
mem_we  out  1  write enable
mem_rdata  in  8  port B read data; valid the cycle after mem_addr is presented with mem_we=0
cursor_row  out  ROW_W  current row
cursor_col  out  COL_W  current column
busy  out  1  scroll or clear in progress

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: cursor (0,0), state IDLE, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, in_ready=1.
- Reset mid-scroll or mid-clear aborts immediately: mem_we=0 from the next cycle. Memory contents are left as they are.
- Reset does not clear the screen.
- busy = (state != IDLE). in_ready = !busy, a registered-state function with no combinational path from in_valid.
- Accept event: in_valid && in_ready at a rising edge E.
  - The mem_* outputs are registered, so any resulting write is driven during the cycle after E.
  - IDLE accepts back-to-back characters at 1 per cycle.
- Accepted-character decode:
  - 0x20..0x7E:
    - Write in_char at cursor_addr; col += 1.
    - If col was COLS-1: col := 0, row += 1.
    - If row was ROWS-1: the character write still happens, row stays ROWS-1, then enter SCROLL.
  - 0x0A (LF): col := 0, row += 1. On the last row, enter SCROLL. No write.
  - 0x0D (CR): col := 0. No write.
  - 0x08 (BS):
    - If col > 0: col -= 1 and write 0x20 at the new position.
    - If col == 0: no-op. There is no reverse wrap.
  - 0x0C (FF): enter CLEAR. Cursor := (0,0) when CLEAR finishes.
  - All other codes: accepted and ignored.
- SCROLL, per destination address d = 0 .. (ROWS-1)*COLS-1:
  - SCR_RD: mem_addr = d+COLS, mem_we = 0.
  - SCR_WAIT: mem_rdata becomes valid.
  - SCR_WR: mem_addr = d, mem_wdata = captured rdata, mem_we = 1.
  - Cost: 3 cycles per character. The first SCR_RD begins in the cycle after the pending character write.
- After the copy, SCR_CLR writes 0x20 to each address of the last row, (ROWS-1)*COLS .. ROWS*COLS-1, one per cycle.
- Scroll then returns to IDLE with cursor (ROWS-1, 0).
- Total busy cycles for a scroll: 3*(ROWS-1)*COLS + COLS.
- CLEAR: writes 0x20 to addresses 0 .. ROWS*COLS-1, one per cycle, then returns to IDLE. busy for ROWS*COLS cycles.
- Address arithmetic:
  - The linear cursor address is kept as an incrementally updated register; no multiplier in the datapath.
  - Incrementing cols wraps at COLS-1, not at 2^COL_W.
  - All counters are sized to hold ROWS*COLS without overflow.
- mem_we is high only in the cases above; every write lasts exactly one cycle.
- in_valid while busy is ignored and the character is not consumed.

Test Plan (COLS=4, ROWS=3, behavioural 1-cycle-latency memory model):
- Reset, then 'A' (0x41) -> one cycle of mem_we=1, addr 0, data 0x41; cursor (0,1); in_ready stays 1.
- "ABCD" back-to-back from (0,0) -> writes to addr 0,1,2,3 on consecutive cycles; cursor (1,0); no stall.
- At (1,2): send 0x0A -> cursor (2,0), no mem_we. Then 0x0D -> cursor unchanged. Then 0x08 at (2,0) -> no write, cursor (2,0).
- Memory holds 0x30+addr. At (2,3) send 'Z' -> write addr 11=0x5A; busy for 28 cycles; final mem[0..7] = old mem[4..11] (including 'Z' at 7); mem[8..11] = 0x20; cursor (2,0); in_valid during busy is not consumed.
- At (1,2) send 0x08 -> write 0x20 at addr 5; cursor (1,1).
- Send 0x0C -> 12 writes of 0x20 to addr 0..11; cursor (0,0). Repeat, asserting reset after 5 clear cycles -> mem_we=0 next cycle; in_ready=1; cursor (0,0); addr 5..11 untouched.
